// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants for encoder and decoder blocks
package seg7_pkg;

    // All segments off (active-low bus idle / blank digit)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns for hex digits 0..F
    // bit order: [0]=top [1]=upper-right [2]=lower-right [3]=bottom
    //            [4]=lower-left [5]=upper-left [6]=centre
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Per-digit classification
    localparam logic [1:0] STAT_BLANK   = 2'b00;
    localparam logic [1:0] STAT_VALID   = 2'b01;
    localparam logic [1:0] STAT_INVALID = 2'b10;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - active-low 7-segment pattern to value/status
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] val,
    output logic [1:0] stat
);

    // Anything that is neither blank nor one of the 16 hex glyphs is invalid
    always_comb begin
        val  = 4'h0;
        stat = STAT_INVALID;
        if (pattern == SEG_BLANK) begin
            stat = STAT_BLANK;
        end
        for (int h = 0; h < 16; h++) begin
            if (pattern == SEG_HEX[h]) begin
                val  = 4'(h);
                stat = STAT_VALID;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment bus readback with change events
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    parameter  int STABLE     = 3,
    localparam int CW         = $clog2(STABLE + 1),
    localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [2*NUM_DIGITS-1:0] digit_stat,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [IW-1:0]           ev_idx,
    output logic [3:0]              ev_val,
    output logic [1:0]              ev_stat,
    output logic                    ev_ovf,
    output logic                    sel_err
);

    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Registered copy of the display bus
    logic [6:0]            in_seg;
    logic [NUM_DIGITS-1:0] in_sel;

    // Per-digit filter state and committed result
    logic [6:0]    cand [NUM_DIGITS];
    logic [CW-1:0] cnt  [NUM_DIGITS];
    logic [6:0]    pat  [NUM_DIGITS];
    logic [3:0]    dval [NUM_DIGITS];
    logic [1:0]    dstat[NUM_DIGITS];

    // Selected-digit view
    logic          sel_legal;
    logic [IW-1:0] sel_idx;
    logic [6:0]    cur_cand;
    logic [CW-1:0] cur_cnt;
    logic [6:0]    cur_pat;
    logic [CW-1:0] cnt_next;
    logic          commit;
    logic [3:0]    dec_val;
    logic [1:0]    dec_stat;

    // Capture the bus once so all decisions work on a stable copy
    always_ff @(posedge clock) begin
        if (reset) begin
            in_seg <= SEG_BLANK;
            in_sel <= '0;
        end else begin
            in_seg <= seg_n;
            in_sel <= dig_sel;
        end
    end

    // One-hot select to digit index; index is only used when the select is legal
    always_comb begin
        sel_legal = $onehot(in_sel);
        sel_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (in_sel[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    assign cur_cand = cand[sel_idx];
    assign cur_cnt  = cnt[sel_idx];
    assign cur_pat  = pat[sel_idx];

    // Stability counter: restart on a new pattern, saturate at the threshold
    always_comb begin
        if (in_seg == cur_cand) begin
            cnt_next = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_ONE;
        end else begin
            cnt_next = CNT_ONE;
        end
    end

    // Commit only when the pattern just became stable and differs from what is shown;
    // after the update cand equals in_seg, so in_seg is the pattern being committed
    assign commit = sel_legal && (cnt_next == CNT_MAX) && (in_seg != cur_pat);

    seg7_pattern_decode u_decode (
        .pattern (in_seg),
        .val     (dec_val),
        .stat    (dec_stat)
    );

    // Per-digit filter update for the sampled digit
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i] <= SEG_BLANK;
                cnt[i]  <= '0;
                pat[i]  <= SEG_BLANK;
            end
        end else if (sel_legal) begin
            cand[sel_idx] <= in_seg;
            cnt[sel_idx]  <= cnt_next;
            if (commit) begin
                pat[sel_idx] <= in_seg;
            end
        end
    end

    // Committed value/status table, updated regardless of event slot occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dval[i]  <= 4'h0;
                dstat[i] <= STAT_BLANK;
            end
        end else if (commit) begin
            dval[sel_idx]  <= dec_val;
            dstat[sel_idx] <= dec_stat;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
        assign digit_val[4*g +: 4]  = dval[g];
        assign digit_stat[2*g +: 2] = dstat[g];
    end

    // One-entry event slot; a commit may refill the slot in the same cycle it is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            ev_valid <= 1'b0;
            ev_idx   <= '0;
            ev_val   <= 4'h0;
            ev_stat  <= STAT_BLANK;
            ev_ovf   <= 1'b0;
        end else if (commit) begin
            if (!ev_valid || ev_ready) begin
                ev_valid <= 1'b1;
                ev_idx   <= sel_idx;
                ev_val   <= dec_val;
                ev_stat  <= dec_stat;
            end else begin
                ev_ovf   <= 1'b1;
            end
        end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

    // Flag each processed sample whose select was zero or multi-hot
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= !sel_legal;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - randomized and directed bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int ND = 6;
    localparam int ST = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [6:0]    seg_n;
    logic [ND-1:0] dig_sel;
    logic [4*ND-1:0] digit_val;
    logic [2*ND-1:0] digit_stat;
    logic          ev_valid;
    logic          ev_ready;
    logic [2:0]    ev_idx;
    logic [3:0]    ev_val;
    logic [1:0]    ev_stat;
    logic          ev_ovf;
    logic          sel_err;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE(ST)) dut (
        .clock      (clock),
        .reset      (reset),
        .seg_n      (seg_n),
        .dig_sel    (dig_sel),
        .digit_val  (digit_val),
        .digit_stat (digit_stat),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_idx     (ev_idx),
        .ev_val     (ev_val),
        .ev_stat    (ev_stat),
        .ev_ovf     (ev_ovf),
        .sel_err    (sel_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference glyph table (active-low) for hex 0..F
    logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model state
    logic [6:0]    m_cand [ND];
    int            m_cnt  [ND];
    logic [6:0]    m_pat  [ND];
    int            m_val  [ND];
    int            m_stat [ND];
    logic          m_ev_valid, m_ovf, m_sel_err;
    int            m_ev_idx, m_ev_val, m_ev_stat;
    logic [6:0]    m_rseg;
    logic [ND-1:0] m_rsel;
    int            ev_seen;
    int            err_seen;

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_cand[i] = 7'h7F; m_cnt[i] = 0; m_pat[i] = 7'h7F; m_val[i] = 0; m_stat[i] = 0;
        end
        m_ev_valid = 0; m_ev_idx = 0; m_ev_val = 0; m_ev_stat = 0; m_ovf = 0; m_sel_err = 0;
        m_rseg = 7'h7F; m_rsel = '0;
    endtask

    task automatic model_sample(input logic [ND-1:0] s, input logic [6:0] p, input logic rdy);
        bit commit = 0;
        int d = 0, v = 0, st = 2;
        m_sel_err = ($countones(s) != 1);
        if (!m_sel_err) begin
            for (int i = 0; i < ND; i++) if (s[i]) d = i;
            if (p == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > ST) ? ST : m_cnt[d] + 1;
            else begin m_cand[d] = p; m_cnt[d] = 1; end
            if (m_cnt[d] == ST && m_cand[d] != m_pat[d]) begin
                commit = 1;
                m_pat[d] = p;
                if (p == 7'h7F) st = 0;
                for (int h = 0; h < 16; h++) if (p == hex_pat[h]) begin v = h; st = 1; end
                m_val[d] = v; m_stat[d] = st;
            end
        end
        if (commit) begin
            if (!m_ev_valid || rdy) begin
                m_ev_valid = 1; m_ev_idx = d; m_ev_val = v; m_ev_stat = st;
            end else m_ovf = 1;
        end else if (m_ev_valid && rdy) m_ev_valid = 0;
    endtask

    task automatic compare_all();
        logic [4*ND-1:0] ev_dv;
        logic [2*ND-1:0] ev_ds;
        for (int i = 0; i < ND; i++) begin
            ev_dv[4*i +: 4] = 4'(m_val[i]);
            ev_ds[2*i +: 2] = 2'(m_stat[i]);
        end
        check("digit_val",  32'(digit_val),  32'(ev_dv));
        check("digit_stat", 32'(digit_stat), 32'(ev_ds));
        check("ev_valid",   32'(ev_valid),   32'(m_ev_valid));
        check("ev_idx",     32'(ev_idx),     32'(m_ev_idx));
        check("ev_val",     32'(ev_val),     32'(m_ev_val));
        check("ev_stat",    32'(ev_stat),    32'(m_ev_stat));
        check("ev_ovf",     32'(ev_ovf),     32'(m_ovf));
        check("sel_err",    32'(sel_err),    32'(m_sel_err));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clock);
        if (reset) model_reset();
        else begin
            model_sample(m_rsel, m_rseg, ev_ready);
            m_rsel = dig_sel;
            m_rseg = seg_n;
        end
        @(negedge clock);
        compare_all();
        if (ev_valid) ev_seen++;
        if (sel_err) err_seen++;
    endtask

    task automatic samp(input logic [ND-1:0] s, input logic [6:0] p, input int n);
        dig_sel = s;
        seg_n   = p;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        reset = 1'b1; dig_sel = '0; seg_n = 7'h7F; ev_ready = 1'b0;
        model_reset();
        ev_seen = 0; err_seen = 0;
        repeat (3) cycle();
        reset = 1'b0;

        // Idle on a blank, legal digit
        samp(6'b000001, 7'h7F, 10);
        check("idle_stat", 32'(digit_stat), 32'h0);
        check("idle_val", 32'(digit_val), 32'h0);
        check("idle_ev", 32'(ev_valid), 32'h0);
        check("idle_selerr", 32'(sel_err), 32'h0);

        // Three stable samples commit digit 0 = 2
        samp(6'b000001, 7'h24, 4);
        check("d0_val2", 32'(digit_val[3:0]), 32'h2);
        check("d0_stat2", 32'(digit_stat[1:0]), 32'h1);
        check("d0_ev", 32'({ev_valid, ev_idx, ev_val}), 32'({1'b1, 3'd0, 4'd2}));
        ev_ready = 1'b1;
        cycle();
        // Two samples then a different glyph: nothing commits
        samp(6'b000001, 7'h12, 2);
        samp(6'b000001, 7'h30, 1);
        samp(6'b000001, 7'h24, 4);
        check("d0_nocommit", 32'(digit_val[3:0]), 32'h2);
        check("d0_noev", 32'(ev_valid), 32'h0);

        // Walk all 16 glyphs on digit 1
        ev_seen = 0;
        for (int h = 0; h < 16; h++) begin
            samp(6'b000010, hex_pat[h], 3);
            if (h > 0) check("d1_step", 32'(digit_val[7:4]), 32'(h - 1));
        end
        samp(6'b000010, 7'h7E, 4);
        check("d1_events", 32'(ev_seen), 32'd17);
        check("d1_invalid", 32'({digit_stat[3:2], digit_val[7:4]}), 32'({2'b10, 4'h0}));
        samp(6'b000010, 7'h7F, 4);
        check("d1_blank", 32'(digit_stat[3:2]), 32'h0);

        // Illegal selects
        err_seen = 0;
        samp(6'b000011, 7'h00, 3);
        samp(6'b000000, 7'h00, 3);
        samp(6'b000001, 7'h24, 2);
        check("selerr_count", 32'(err_seen), 32'd6);

        // Event drop while slot is held, then accept and commit together
        ev_ready = 1'b0;
        samp(6'b000001, 7'h12, 4);
        samp(6'b000100, 7'h10, 4);
        check("ovf_slot", 32'({ev_valid, ev_idx, ev_val}), 32'({1'b1, 3'd0, 4'd5}));
        check("ovf_flag", 32'(ev_ovf), 32'h1);
        check("ovf_d2", 32'(digit_val[11:8]), 32'h9);
        samp(6'b000100, 7'h40, 3);
        ev_ready = 1'b1;
        cycle();
        check("accept_load", 32'({ev_valid, ev_idx, ev_val}), 32'({1'b1, 3'd2, 4'd0}));

        // Reset mid-count on digit 3
        samp(6'b001000, 7'h30, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        samp(6'b001000, 7'h30, 1);
        samp(6'b000001, 7'h7F, 2);
        check("rst_nocommit", 32'({digit_stat[7:6], ev_valid, ev_ovf}), 32'h0);
        samp(6'b001000, 7'h30, 3);
        samp(6'b000001, 7'h7F, 1);
        check("rst_commit", 32'({digit_stat[7:6], digit_val[15:12]}), 32'({2'b01, 4'h3}));

        // Randomized traffic
        for (int r = 0; r < 400; r++) begin
            logic [ND-1:0] s;
            logic [6:0]    p;
            int            pick = $urandom_range(0, 99);
            s = (pick < 85) ? ND'(1 << $urandom_range(0, ND - 1)) : ND'($urandom);
            pick = $urandom_range(0, 99);
            if (pick < 60)      p = hex_pat[$urandom_range(0, 15)];
            else if (pick < 75) p = 7'h7F;
            else                p = 7'($urandom);
            ev_ready = 1'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            samp(s, p, $urandom_range(1, 4));
            reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
